id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage: register file with write-through bypass, registered ID/EX
//  output slot with valid/ready handshake, and a load-use scoreboard that stalls the
//  fetch side. Sits between fetch (in_*) and execute (out_*); takes write-back on wb_*.
// PARAMETERS
//  DATA_W   32  register/datapath width (>=16)
//  NREGS    32  number of architectural registers (power of two, <=32)
//  ADDR_W   5   register index width; must equal log2(NREGS)
//  R0_ZERO  1   1: register 0 hard-wired to zero, never written or scoreboarded
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-low
//  in_valid     in   1       ins/npc_i hold a fetched instruction
//  in_ready     out  1       stage accepts the instruction this cycle
//  ins          in   32      instruction word
//  npc_i        in   DATA_W  next-PC of the instruction
//  wb_we        in   1       write-back enable
//  wb_addr      in   ADDR_W  write-back register index
//  wb_data      in   DATA_W  write-back data
//  flush        in   1       discard the slot contents (branch/exception redirect)
//  out_valid    out  1       output slot holds a decoded instruction
//  out_ready    in   1       execute consumes the slot this cycle
//  op,func      out  6,6     ins[31:26], ins[5:0]
//  jpc          out  26      ins[25:0]
//  data_a       out  DATA_W  value of rs (ins[25:21])
//  data_b       out  DATA_W  value of rt (ins[20:16])
//  simm,zimm    out  DATA_W  sign-/zero-extended ins[15:0]
//  dst_reg      out  ADDR_W  destination index (0 when none)
//  reg_write    out  1       instruction writes dst_reg
//  mem_read     out  1       load
//  mem_write    out  1       store
//  npc_o        out  DATA_W  registered npc_i
// BEHAVIOUR
//  Reset: all registers, all out_* fields, out_valid, scoreboard = 0. Async assert,
//   sync release.
//  Register file: write at posedge when wb_we && !(R0_ZERO && wb_addr==0). Reads
//   combinational; if wb_we && wb_addr==src && src!=0 (R0_ZERO) read returns wb_data.
//   Index 0 reads 0 when R0_ZERO.
//  Decode (op): 000000 SPECIAL dst=rd, wr=1; 010000 COP0 dst=rt, wr=1;
//   001000-001111 I-ALU dst=rt, wr=1; 100000/100001/100011/100100/100101 loads dst=rt,
//   wr=1, mem_read=1; 101000/101001/101011 stores mem_write=1, dst=0;
//   000011 JAL / 000001 REGIMM dst=31, wr=1; others dst=0, all flags 0.
//  Scoreboard: NREGS bits. Bit[dst] set on slot output fire (out_valid&&out_ready)
//   of a load; bit[wb_addr] cleared on wb_we. Same reg set+clear in one cycle: set wins.
//  Hazard: hazard = in_valid && (sb[rs] || sb[rt] || slot holds load whose dst==rs or
//   rt and dst!=0). Conservative: rt checked for every opcode.
//  Handshake: in_ready = !hazard && (!out_valid || out_ready). Accept = in_valid &&
//   in_ready: slot loads all decoded fields, out_valid=1 next cycle (latency 1).
//   Output fire with no accept: out_valid=0. No accept, no fire: slot holds stable.
//  Flush: out_valid=0 next cycle; in_ready forced 0 that cycle (no accept); scoreboard
//   untouched (older loads still write back). Flush beats accept and fire.
//  Bypass applies at capture time only; slot data is not updated by later write-backs
//   (scoreboard guarantees loads; execute forwards ALU results).
// TESTING
//  1 Reset mid-run: rst low with out_valid=1 -> out_valid=0, regs read 0, sb=0 at once.
//  2 wb_we addr=5 data=0xDEADBEEF same cycle as accept of ADD rs=5 -> data_a=0xDEADBEEF.
//  3 Write addr=0 data=0x1234 then read r0 -> 0; scoreboard bit 0 never sets on LW r0.
//  4 LW r8 then ADD rs=8: in_ready=0 until wb_we addr=8 -> ADD accepted next cycle,
//    data_a=write-back value.
//  5 out_ready=0 for 3 cycles with in_valid=1 -> slot stable, in_ready=0; release ->
//    one fire plus one accept same cycle, no gap.
//  6 flush with in_valid=1, out_ready=1 -> out_valid=0, instruction not accepted.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Decode stage: register file with write-through bypass, registered ID/EX slot
// with valid/ready handshake, and a load-use scoreboard that stalls fetch.
module id_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int ADDR_W  = 5,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ins,
  input  logic [DATA_W-1:0] npc_i,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [25:0]       jpc,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] simm,
  output logic [DATA_W-1:0] zimm,
  output logic [ADDR_W-1:0] dst_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] npc_o
);

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [NREGS-1:0]  sb_q, sb_d;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [ADDR_W-1:0] dec_dst;
  logic              dec_wr, dec_mr, dec_mw;
  logic              slot_load_hit, hazard, accept, fire;

  logic              out_valid_q;
  logic [5:0]        op_q, func_q;
  logic [25:0]       jpc_q;
  logic [DATA_W-1:0] data_a_q, data_b_q, simm_q, zimm_q, npc_q;
  logic [ADDR_W-1:0] dst_q;
  logic              wr_q, mr_q, mw_q;

  assign rs = ins[21 +: ADDR_W];
  assign rt = ins[16 +: ADDR_W];
  assign rd = ins[11 +: ADDR_W];

  // Bypass first, then the r0 override so a write to r0 never leaks through.
  always_comb begin
    rdata_a = rf_q[rs];
    rdata_b = rf_q[rt];
    if (wb_we && wb_addr == rs) rdata_a = wb_data;
    if (wb_we && wb_addr == rt) rdata_b = wb_data;
    if (R0_ZERO && rs == '0) rdata_a = '0;
    if (R0_ZERO && rt == '0) rdata_b = '0;
  end

  always_comb begin
    dec_dst = '0;
    dec_wr  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    casez (ins[31:26])
      6'b000000:           begin dec_dst = rd; dec_wr = 1'b1; end
      6'b010000, 6'b001???: begin dec_dst = rt; dec_wr = 1'b1; end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        dec_dst = rt;
        dec_wr  = 1'b1;
        dec_mr  = 1'b1;
      end
      6'b101000, 6'b101001, 6'b101011: dec_mw = 1'b1;
      6'b000011, 6'b000001: begin dec_dst = '1; dec_wr = 1'b1; end
      default: ;
    endcase
  end

  // A load still in the slot has not reached the scoreboard yet.
  assign slot_load_hit = out_valid_q && mr_q && (dst_q != '0) && ((dst_q == rs) || (dst_q == rt));
  assign hazard        = in_valid && (sb_q[rs] || sb_q[rt] || slot_load_hit);
  assign in_ready      = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept        = in_valid && in_ready;
  assign fire          = out_valid_q && out_ready && !flush;

  always_comb begin
    sb_d = sb_q;
    if (wb_we) sb_d[wb_addr] = 1'b0;
    if (fire && mr_q) sb_d[dst_q] = 1'b1;
    if (R0_ZERO) sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[ADDR_W'(i)] <= '0;
    end else if (wb_we && !(R0_ZERO && wb_addr == '0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q        <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      func_q      <= '0;
      jpc_q       <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      simm_q      <= '0;
      zimm_q      <= '0;
      npc_q       <= '0;
      dst_q       <= '0;
      wr_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
    end else begin
      sb_q <= sb_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        op_q        <= ins[31:26];
        func_q      <= ins[5:0];
        jpc_q       <= ins[25:0];
        data_a_q    <= rdata_a;
        data_b_q    <= rdata_b;
        simm_q      <= {{(DATA_W-16){ins[15]}}, ins[15:0]};
        zimm_q      <= {{(DATA_W-16){1'b0}}, ins[15:0]};
        npc_q       <= npc_i;
        dst_q       <= dec_dst;
        wr_q        <= dec_wr;
        mr_q        <= dec_mr;
        mw_q        <= dec_mw;
      end else if (fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign func      = func_q;
  assign jpc       = jpc_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign simm      = simm_q;
  assign zimm      = zimm_q;
  assign npc_o     = npc_q;
  assign dst_reg   = dst_q;
  assign reg_write = wr_q;
  assign mem_read  = mr_q;
  assign mem_write = mw_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the decode stage.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] ins, npc_i;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush, out_valid, out_ready;
  logic [5:0]  op, func;
  logic [25:0] jpc;
  logic [31:0] data_a, data_b, simm, zimm, npc_o;
  logic [4:0]  dst_reg;
  logic        reg_write, mem_read, mem_write;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
    .npc_i(npc_i), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op(op),
    .func(func), .jpc(jpc), .data_a(data_a), .data_b(data_b), .simm(simm),
    .zimm(zimm), .dst_reg(dst_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .npc_o(npc_o)
  );

  typedef struct {
    logic [5:0]  op, func;
    logic [25:0] jpc;
    logic [31:0] a, b, simm, zimm, npc;
    logic [4:0]  dst;
    logic        wr, mr, mw;
  } slot_t;

  logic [31:0] mrf [32];
  bit          mpend [32];
  bit          mval;
  slot_t       ms;
  bit          last_acc;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mk(input int o, input int s, input int t, input int imm);
    logic [31:0] w;
    w = (o << 26) | (s << 21) | (t << 16) | (imm & 32'hFFFF);
    return w;
  endfunction

  function automatic void mdec(input logic [31:0] i, output logic [4:0] dst,
                               output logic wr, output logic mr, output logic mw);
    int o;
    o = int'(i[31:26]);
    dst = 5'd0; wr = 1'b0; mr = 1'b0; mw = 1'b0;
    if (o == 0) begin dst = i[15:11]; wr = 1'b1; end
    else if (o == 16 || (o >= 8 && o <= 15)) begin dst = i[20:16]; wr = 1'b1; end
    else if (o == 32 || o == 33 || o == 35 || o == 36 || o == 37) begin
      dst = i[20:16]; wr = 1'b1; mr = 1'b1;
    end
    else if (o == 40 || o == 41 || o == 43) mw = 1'b1;
    else if (o == 3 || o == 1) begin dst = 5'd31; wr = 1'b1; end
  endfunction

  function automatic logic [31:0] mread(input int src);
    if (src == 0) return 32'h0;
    if (wb_we && int'(wb_addr) == src) return wb_data;
    return mrf[src];
  endfunction

  function automatic bit mready();
    int  s, t;
    bit  slotload, haz;
    s = int'(ins[25:21]);
    t = int'(ins[20:16]);
    slotload = mval && ms.mr && ms.dst != 0 && (int'(ms.dst) == s || int'(ms.dst) == t);
    haz = in_valid && (mpend[s] || mpend[t] || slotload);
    return !flush && !haz && (!mval || out_ready);
  endfunction

  task automatic mreset();
    for (int r = 0; r < 32; r++) begin mrf[r] = 32'h0; mpend[r] = 1'b0; end
    mval = 1'b0;
    last_acc = 1'b0;
  endtask

  task automatic compare();
    chk("in_ready", in_ready, mready());
    chk("out_valid", out_valid, mval);
    if (mval) begin
      chk("op", op, ms.op);
      chk("func", func, ms.func);
      chk("jpc", jpc, ms.jpc);
      chk("data_a", data_a, ms.a);
      chk("data_b", data_b, ms.b);
      chk("simm", simm, ms.simm);
      chk("zimm", zimm, ms.zimm);
      chk("npc_o", npc_o, ms.npc);
      chk("dst_reg", dst_reg, ms.dst);
      chk("reg_write", reg_write, ms.wr);
      chk("mem_read", mem_read, ms.mr);
      chk("mem_write", mem_write, ms.mw);
    end
  endtask

  task automatic advance();
    bit    acc, fire;
    slot_t ns;
    if (!rst) begin mreset(); return; end
    acc  = in_valid && mready();
    fire = mval && out_ready && !flush;
    ns.op   = ins[31:26];
    ns.func = ins[5:0];
    ns.jpc  = ins[25:0];
    ns.a    = mread(int'(ins[25:21]));
    ns.b    = mread(int'(ins[20:16]));
    ns.simm = {{16{ins[15]}}, ins[15:0]};
    ns.zimm = {16'h0, ins[15:0]};
    ns.npc  = npc_i;
    mdec(ins, ns.dst, ns.wr, ns.mr, ns.mw);
    if (wb_we) mpend[int'(wb_addr)] = 1'b0;
    if (fire && ms.mr && ms.dst != 0) mpend[int'(ms.dst)] = 1'b1;
    if (wb_we && wb_addr != 0) mrf[int'(wb_addr)] = wb_data;
    if (flush) mval = 1'b0;
    else if (acc) begin ms = ns; mval = 1'b1; end
    else if (fire) mval = 1'b0;
    last_acc = acc;
  endtask

  // Inputs are driven at the negedge; DUT is sampled 1ns later.
  task automatic cycle();
    #1;
    compare();
    advance();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_we = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  function automatic logic [31:0] rand_ins();
    int ops [16] = '{0, 16, 8, 9, 13, 15, 32, 35, 37, 40, 43, 3, 1, 2, 4, 63};
    int o;
    o = ops[$urandom_range(0, 15)];
    return mk(o, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
  endfunction

  task automatic rand_inputs();
    int q[$];
    if (!(in_valid && !last_acc)) begin
      ins   = rand_ins();
      npc_i = $urandom;
    end
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 3) != 0);
    flush     = ($urandom_range(0, 31) == 0);
    for (int r = 0; r < 32; r++) if (mpend[r]) q.push_back(r);
    wb_we   = 1'b0;
    wb_addr = 5'd0;
    if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
      wb_we = 1'b1; wb_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
    end else if ($urandom_range(0, 7) == 0) begin
      wb_we = 1'b1; wb_addr = 5'($urandom_range(0, 31));
    end
    wb_data = $urandom;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; ins = '0; npc_i = '0; wb_we = 1'b0;
    wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    mreset();
    @(negedge clk);
    cycle(); cycle();
    chk("reset_out_valid", out_valid, 1'b0);
    rst = 1'b1;
    idle(); cycle();

    // write-through bypass on r5 at capture
    in_valid = 1'b1; ins = mk(0, 5, 6, (7 << 11) | 32); npc_i = 32'h100;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    cycle(); idle();
    chk("t2_data_a", data_a, 32'hDEADBEEF);
    chk("t2_data_b", data_b, 32'h0);
    chk("t2_dst", dst_reg, 5'd7);
    cycle(); cycle();

    // r0 ignores writes and never scoreboards
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; cycle(); idle();
    in_valid = 1'b1; ins = mk(0, 0, 0, (1 << 11) | 32); cycle(); idle();
    chk("t3_r0_a", data_a, 32'h0);
    chk("t3_r0_b", data_b, 32'h0);
    cycle();
    in_valid = 1'b1; ins = mk(35, 1, 0, 4); cycle(); idle(); cycle();
    in_valid = 1'b1; ins = mk(0, 0, 0, (2 << 11) | 32);
    #1 chk("t3_no_sb_r0", in_ready, 1'b1);
    cycle(); idle(); cycle(); cycle();

    // load-use stall on r8
    in_valid = 1'b1; ins = mk(35, 1, 8, 0); cycle();
    ins = mk(0, 8, 9, (10 << 11) | 32);
    #1 chk("t4_stall_slot", in_ready, 1'b0);
    cycle();
    #1 chk("t4_stall_sb", in_ready, 1'b0);
    cycle();
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hCAFEF00D;
    #1 chk("t4_stall_wb", in_ready, 1'b0);
    cycle();
    wb_we = 1'b0;
    #1 chk("t4_release", in_ready, 1'b1);
    cycle(); idle();
    chk("t4_data_a", data_a, 32'hCAFEF00D);
    chk("t4_valid", out_valid, 1'b1);
    cycle(); cycle();

    // backpressure then simultaneous fire + accept
    in_valid = 1'b1; ins = mk(13, 2, 3, 16'h00FF); out_ready = 1'b0; cycle();
    ins = mk(9, 1, 4, 16'h8001);
    repeat (3) begin
      #1 chk("t5_stalled", in_ready, 1'b0);
      chk("t5_slot_op", op, 6'd13);
      cycle();
    end
    out_ready = 1'b1;
    #1 chk("t5_release", in_ready, 1'b1);
    cycle(); idle();
    chk("t5_next_op", op, 6'd9);
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_simm", simm, 32'hFFFF8001);
    chk("t5_zimm", zimm, 32'h00008001);
    cycle(); cycle();

    // flush drops slot and blocks accept
    in_valid = 1'b1; ins = mk(8, 1, 2, 5); cycle();
    flush = 1'b1; ins = mk(8, 3, 4, 6);
    #1 chk("t6_flush_ready", in_ready, 1'b0);
    cycle(); idle();
    chk("t6_out_valid", out_valid, 1'b0);
    cycle();

    repeat (3000) begin rand_inputs(); cycle(); end

    idle(); cycle(); cycle();
    for (int r = 0; r < 32; r++) if (mpend[r]) begin
      idle(); wb_we = 1'b1; wb_addr = 5'(r); wb_data = $urandom; cycle();
    end
    idle(); cycle();

    // reset mid-run with a pending load and a full slot
    in_valid = 1'b1; ins = mk(35, 1, 12, 0); cycle(); idle(); cycle();
    in_valid = 1'b1; ins = mk(15, 0, 20, 7); out_ready = 1'b0; cycle();
    chk("t1_pre_valid", out_valid, 1'b1);
    rst = 1'b0; mreset(); idle();
    #1 chk("t1_valid", out_valid, 1'b0);
    in_valid = 1'b1; ins = mk(0, 12, 5, (7 << 11) | 32);
    #1 chk("t1_sb_clear", in_ready, 1'b1);
    cycle();
    rst = 1'b1; cycle(); idle();
    chk("t1_regs_a", data_a, 32'h0);
    chk("t1_regs_b", data_b, 32'h0);
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
